// File: rtl/uart_ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Round-robin on contention, zero wait states for a lone requester, sticky out-of-range flag.
module uart_ram_arbiter #(
  parameter int DEPTH = 51200,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  // master 0
  input  logic [AW-1:0] m0_address,
  input  logic [3:0]    m0_byteenable,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [31:0]   m0_writedata,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,
  // master 1
  input  logic [AW-1:0] m1_address,
  input  logic [3:0]    m1_byteenable,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [31:0]   m1_writedata,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,
  // RAM port
  output logic [AW-1:0] ram_address,
  output logic [3:0]    ram_byteenable,
  output logic [31:0]   ram_writedata,
  output logic          ram_chipselect,
  output logic          ram_write,
  output logic          ram_clken,
  input  logic [31:0]   ram_readdata,
  // control / status
  input  logic          freeze,
  input  logic          err_clear,
  output logic          err_oor
);

  // Handshake: a transfer by master N is accepted on the rising edge where
  // (mN_read | mN_write) is high and mN_waitrequest is low; a read returns
  // exactly one cycle later with mN_readdatavalid high for one cycle.

  logic          last_grant_q, last_grant_d;
  logic          pend_q, pend_d;
  logic          owner_q, owner_d;
  logic          pend_oor_q, pend_oor_d;
  logic          err_oor_q, err_oor_d;

  logic          req0, req1;
  logic          grant0, grant1, grant_any;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_be;
  logic [31:0]   sel_wdata;
  logic          sel_write;
  logic          in_range;

  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Nothing is granted during reset or freeze, so nothing can be accepted.
    if (!reset && !freeze) begin
      if (req0 && req1) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    grant_any = grant0 | grant1;
  end

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    if (grant0) begin
      sel_addr  = m0_address;
      sel_be    = m0_byteenable;
      sel_wdata = m0_writedata;
      sel_write = m0_write;
    end else if (grant1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = m1_write;
    end
    in_range = 32'(sel_addr) < 32'(DEPTH);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1)      last_grant_d = 1'b1;
    else if (grant0) last_grant_d = 1'b0;
    // Write wins when read and write are both high.
    pend_d     = grant_any & ~sel_write;
    owner_d    = grant1;
    pend_oor_d = ~in_range;
    // Set wins over a simultaneous clear.
    err_oor_d  = (grant_any & ~in_range) | (err_oor_q & ~err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      pend_q       <= 1'b0;
      owner_q      <= 1'b0;
      pend_oor_q   <= 1'b0;
      err_oor_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      owner_q      <= owner_d;
      pend_oor_q   <= pend_oor_d;
      err_oor_q    <= err_oor_d;
    end
  end

  assign m0_waitrequest   = ~grant0;
  assign m1_waitrequest   = ~grant1;

  assign ram_address      = sel_addr;
  assign ram_byteenable   = sel_be;
  assign ram_writedata    = sel_wdata;
  assign ram_chipselect   = grant_any & in_range;
  assign ram_write        = grant_any & in_range & sel_write;
  assign ram_clken        = 1'b1;

  assign m0_readdatavalid = pend_q & ~owner_q;
  assign m1_readdatavalid = pend_q & owner_q;
  assign m0_readdata      = (m0_readdatavalid && !pend_oor_q) ? ram_readdata : 32'h0;
  assign m1_readdata      = (m1_readdatavalid && !pend_oor_q) ? ram_readdata : 32'h0;

  assign err_oor          = err_oor_q;

endmodule

// File: doc/uart_ram_arbiter.md
UART_RAM_ARBITER -- requirements
Module: uart_ram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 51200, number of 32-bit words in the attached RAM.
REQ-002 SHALL have parameter AW, default 16, word-address width.
REQ-003 SHALL have ports clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports mN_address  in  AW  word address, N = 0,1.
REQ-006 SHALL have ports mN_byteenable  in  4  byte lanes for writes, N = 0,1.
REQ-007 SHALL have ports mN_read / mN_write  in  1 each  transfer request, N = 0,1.
REQ-008 SHALL have ports mN_writedata  in  32  write data, N = 0,1.
REQ-009 SHALL have ports mN_waitrequest  out  1  stall, transfer accepted on edge where request high and waitrequest low, N = 0,1.
REQ-010 SHALL have ports mN_readdata  out  32 and mN_readdatavalid  out  1  read return, N = 0,1.
REQ-011 SHALL have ports ram_address  out  AW, ram_byteenable  out  4, ram_writedata  out  32, ram_chipselect  out  1, ram_write  out  1, ram_clken  out  1  RAM port.
REQ-012 SHALL have port ram_readdata  in  32  RAM output, valid one cycle after address is registered.
REQ-013 SHALL have ports freeze  in  1  hold off new grants, err_clear  in  1  clear error, err_oor  out  1  sticky out-of-range flag.

Function
REQ-014 SHALL treat master N as requesting when mN_read | mN_write; when both are high, SHALL perform a write and ignore the read.
REQ-015 SHALL grant combinationally in the same cycle: sole requester granted; on contention, master not granted last (last_grant register) is granted.
REQ-016 SHALL update last_grant to N on every accepted transfer by master N; last_grant unchanged otherwise.
REQ-017 SHALL drive mN_waitrequest = ~grantN (high when not granted, including idle).
REQ-018 SHALL, when freeze = 1, grant no master (both waitrequest high) and not alter last_grant; in-flight read return still completes.
REQ-019 SHALL mux the granted master's address, byteenable, writedata onto ram_*; with no grant, ram_* data outputs = 0.
REQ-020 SHALL drive ram_chipselect = grant_any & (address < DEPTH); ram_write = ram_chipselect & granted write.
REQ-021 SHALL hold ram_clken = 1 at all times.
REQ-022 SHALL sustain one accepted transfer per cycle, zero wait states for a sole requester, back-to-back.
REQ-023 SHALL assert mN_readdatavalid exactly one cycle after master N's read is accepted, for one cycle, via registered pending flag and owner bit.
REQ-024 SHALL drive mN_readdata = ram_readdata when the in-range read is returning, 0x00000000 for an out-of-range read, 0 otherwise.
REQ-025 SHALL drop out-of-range writes (address >= DEPTH) without RAM access and still accept them (waitrequest low when granted).
REQ-026 SHALL set err_oor on the edge following any accepted out-of-range access; err_clear = 1 clears it; simultaneous set and clear: set wins.
REQ-027 SHALL bound waiting: with both masters requesting continuously, grants strictly alternate, maximum wait 1 cycle.

Reset
REQ-028 SHALL, while reset = 1, force last_grant = 1 (m0 wins first contention), pending read flag = 0, err_oor = 0, both readdatavalid = 0.
REQ-029 SHALL discard a read accepted in the cycle reset asserts: no readdatavalid after reset release.
REQ-030 SHALL keep waitrequest outputs combinational from requests during reset only as permitted by REQ-017; no transfer is accepted while reset = 1.

Verification
REQ-031 SHALL test: m0 writes 0xDEADBEEF to addr 5, byteenable 0xF, then reads addr 5 -> zero wait, readdatavalid one cycle later, readdata 0xDEADBEEF.
REQ-032 SHALL test: m0 and m1 read continuously from reset -> grants m0,m1,m0,m1..., each readdatavalid to correct master one cycle after acceptance.
REQ-033 SHALL test: m1 writes 0x11223344 to addr 7 with byteenable 0x3 over prior 0xFFFFFFFF -> readback 0xFFFF3344.
REQ-034 SHALL test: m0 write to addr 51200 -> ram_chipselect 0, err_oor = 1 next cycle; read addr 60000 -> readdata 0, readdatavalid 1; err_clear -> err_oor 0.
REQ-035 SHALL test: freeze = 1 for 3 cycles during m0 reads -> both waitrequest high, in-flight read still returns; released -> m0 granted same cycle.
REQ-036 SHALL test: reset pulsed in cycle a read is accepted -> no readdatavalid afterwards, err_oor 0, first contention grants m0.
